// File: rtl/platform_button_ctrl_if.sv
// Nios II slave bus for the push-button controller: register select, write strobe and data, registered read data.
interface platform_button_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write, writedata, input readdata);
  modport slave  (input address, chipselect, write, writedata, output readdata);
endinterface

// File: rtl/platform_button_ctrl.sv
// Push-button controller: per-pin synchroniser and debouncer, W1C press capture,
// maskable level interrupt, four-word register slave.

module platform_button_lane (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pin,
  input  logic [15:0] nm1,
  output logic        stable,
  output logic        press
);
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        stable_q, stable_d;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d  = pin;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q >= nm1) begin
      // >= rather than == so a shrunk RELOAD commits on the next mismatching cycle
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign stable = stable_q;
  assign press  = stable_q & ~stable_d;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

module platform_button_ctrl #(
  parameter int WIDTH            = 8,
  parameter int DEBOUNCE_DEFAULT = 50000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  platform_button_ctrl_if.slave bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);
  localparam logic [1:0] A_DATA = 2'd0, A_MASK = 2'd1, A_CAP = 2'd2, A_RELOAD = 2'd3;

  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [15:0]      reload_q, reload_d;
  logic [31:0]      rd_q, rd_d;
  logic             irq_q, irq_d;
  logic [15:0]      nm1;
  logic [WIDTH-1:0] stable, press;
  logic             wen;
  logic             unused_wd;

  assign unused_wd = ^bus.writedata;

  // RELOAD of 0 behaves as 1, so the terminal count saturates at 0
  always_comb nm1 = (reload_q == 16'd0) ? 16'd0 : reload_q - 16'd1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    platform_button_lane u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .pin     (in_port[i]),
      .nm1     (nm1),
      .stable  (stable[i]),
      .press   (press[i])
    );
  end

  assign wen = bus.chipselect & bus.write;

  always_comb begin
    mask_d   = mask_q;
    cap_d    = cap_q;
    reload_d = reload_q;
    rd_d     = '0;
    irq_d    = |(cap_q & mask_q);
    if (wen) begin
      case (bus.address)
        A_MASK:   mask_d   = bus.writedata[WIDTH-1:0];
        A_CAP:    cap_d    = cap_q & ~bus.writedata[WIDTH-1:0];
        A_RELOAD: reload_d = bus.writedata[15:0];
        default:  ;
      endcase
    end
    // press applied after the clear so a same-cycle set wins
    cap_d = cap_d | press;
    if (bus.chipselect) begin
      case (bus.address)
        A_DATA:  rd_d[WIDTH-1:0] = stable;
        A_MASK:  rd_d[WIDTH-1:0] = mask_q;
        A_CAP:   rd_d[WIDTH-1:0] = cap_q;
        default: rd_d[15:0]      = reload_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_q   <= '0;
      cap_q    <= '0;
      reload_q <= 16'(DEBOUNCE_DEFAULT);
      rd_q     <= '0;
      irq_q    <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      cap_q    <= cap_d;
      reload_q <= reload_d;
      rd_q     <= rd_d;
      irq_q    <= irq_d;
    end
  end

  assign bus.readdata = rd_q;
  assign irq          = irq_q;
endmodule

// File: tb/tb_platform_button_ctrl.sv
// Scoreboarded random + directed bench for platform_button_ctrl against a run-length debounce model.
module tb_platform_button_ctrl;
  localparam int W    = 8;
  localparam int DDEF = 20;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] in_port;
  logic         irq;

  platform_button_ctrl_if bus_if ();

  platform_button_ctrl #(.WIDTH(W), .DEBOUNCE_DEFAULT(DDEF)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .in_port (in_port),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] rd; logic irq; } exp_t;
  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: pins reach the debouncer two edges late; a bit commits once it has
  // spent N_eff consecutive synced cycles away from its stable value.
  logic [W-1:0] m_s1, m_s2, m_st, m_mask, m_cap;
  int           m_run[W];
  logic [15:0]  m_rel;
  logic [W-1:0] pin_v;

  task automatic step(input logic rst_n, input logic [1:0] a, input logic cs, input logic wr,
                      input logic [31:0] wd);
    exp_t         e;
    int           neff;
    logic [W-1:0] pr;
    @(negedge clk);
    reset_n              = rst_n;
    bus_if.address       = a;
    bus_if.chipselect    = cs;
    bus_if.write         = wr;
    bus_if.writedata     = wd;
    in_port              = pin_v;
    if (!rst_n) begin
      e.rd = 0; e.irq = 0;
      m_s1 = '1; m_s2 = '1; m_st = '1; m_mask = 0; m_cap = 0; m_rel = 16'(DDEF);
      for (int b = 0; b < W; b++) m_run[b] = 0;
    end else begin
      e.rd = 0;
      if (cs) begin
        case (a)
          2'd0: e.rd = 32'(m_st);
          2'd1: e.rd = 32'(m_mask);
          2'd2: e.rd = 32'(m_cap);
          default: e.rd = 32'(m_rel);
        endcase
      end
      e.irq = |(m_cap & m_mask);
      neff = (m_rel == 0) ? 1 : int'(m_rel);
      pr = 0;
      for (int b = 0; b < W; b++) begin
        if (m_s2[b] == m_st[b]) m_run[b] = 0;
        else begin
          m_run[b]++;
          if (m_run[b] >= neff) begin
            if (!m_s2[b]) pr[b] = 1'b1;
            m_st[b] = m_s2[b];
            m_run[b] = 0;
          end
        end
      end
      if (cs && wr) begin
        case (a)
          2'd1: m_mask = wd[W-1:0];
          2'd2: m_cap  = m_cap & ~wd[W-1:0];
          2'd3: m_rel  = wd[15:0];
          default: ;
        endcase
      end
      m_cap = m_cap | pr;
      m_s2 = m_s1;
      m_s1 = pin_v;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
  endtask
  task automatic rd(input logic [1:0] a, input int n);
    for (int i = 0; i < n; i++) step(1, a, 1, 0, 0);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    step(1, a, 1, 1, d);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if (bus_if.readdata !== e.rd) begin
          n_bad++;
          $display("FAIL readdata got %h expected %h at %0t", bus_if.readdata, e.rd, $time);
        end
        n_cmp++;
        if (irq !== e.irq) begin
          n_bad++;
          $display("FAIL irq got %b expected %b at %0t", irq, e.irq, $time);
        end
      end
    end
  end

  initial begin : stim
    logic [1:0] a;
    int op;
    pin_v = '0;
    reset_n = 1'b0;
    bus_if.address = 0; bus_if.chipselect = 0; bus_if.write = 0; bus_if.writedata = 0;
    in_port = '0;
    // reset with pins held pressed, then watch DATA until the default debounce elapses
    repeat (3) step(0, 0, 0, 0, 0);
    rd(0, DDEF + 4);
    rd(3, 1);
    pin_v = '1;
    rd(0, DDEF + 4);
    rd(2, 1);
    // bounce rejection
    wr(3, 8);
    repeat (4) begin
      pin_v[0] = 1'b0; rd(0, 3); rd(2, 2);
      pin_v[0] = 1'b1; rd(0, 3); rd(2, 2);
    end
    // clean press with mask
    wr(1, 32'h01);
    pin_v[0] = 1'b0;
    rd(0, 10); rd(2, 4);
    pin_v[0] = 1'b1;
    rd(0, 12); rd(2, 2);
    // W1C and masking
    pin_v[2] = 1'b0; idle(12);
    pin_v[2] = 1'b1; idle(12);
    wr(1, 32'h04);
    rd(2, 1);
    wr(2, 32'h04);
    rd(2, 2);
    wr(2, 32'h00);
    rd(2, 1);
    wr(2, 32'hFF); idle(2);
    // set/clear collision on bit1
    pin_v[1] = 1'b0; idle(1);
    idle(8);
    wr(2, 32'h02);
    rd(2, 2);
    pin_v[1] = 1'b1; idle(12);
    // RELOAD 0: single-cycle pulse
    wr(3, 0);
    pin_v[3] = 1'b0; rd(0, 1);
    pin_v[3] = 1'b1; rd(0, 5); rd(2, 1);
    // reset mid-count
    wr(3, 8);
    wr(2, 32'hFF);
    pin_v[4] = 1'b0;
    rd(0, 7);
    step(0, 0, 0, 0, 0);
    rd(2, 2); rd(0, DDEF + 4); rd(2, 1);
    pin_v[4] = 1'b1; idle(DDEF + 4);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < W; b++) if ($urandom_range(0, 7) == 0) pin_v[b] = ~pin_v[b];
      op = $urandom_range(0, 19);
      a  = 2'($urandom_range(0, 3));
      if (op == 19 && $urandom_range(0, 9) == 0) step(0, a, 1, 1, $urandom);
      else if (op < 10) rd(a, 1);
      else if (op == 10) wr(1, $urandom);
      else if (op == 11) wr(2, $urandom);
      else if (op == 12) wr(3, 32'($urandom_range(0, 6)));
      else if (op == 13) wr(0, $urandom);
      else if (op == 14) step(1, a, 0, 1, $urandom);
      else idle(1);
    end
    idle(2);
    @(posedge clk);
    #2;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got %0d left expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/platform_button_ctrl.md
# platform_button_ctrl

Debounce, edge-capture and interrupt controller for the board push-button inputs. It is a memory-mapped slave on the Nios II system bus, used in place of the raw read-only button port. It synchronises and debounces each active-low button, latches press events in a write-1-to-clear capture register, and raises a maskable level interrupt to the CPU.

## Interface
- WIDTH, 8, number of button inputs (1..32)
- DEBOUNCE_DEFAULT, 50000, reset value of the debounce reload register, in clk cycles (1..65535)
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- address  in  2  register select (word address)
- chipselect  in  1  slave select; qualifies write and read capture
- write  in  1  write strobe, valid only with chipselect
- writedata  in  32  write data
- readdata  out  32  registered read data, zero-extended
- in_port  in  WIDTH  raw asynchronous button pins, active-low (0 = pressed)
- irq  out  1  level interrupt, registered

## Operation
- Register map:
  - 0 DATA: RO, debounced state, bits [WIDTH-1:0]
  - 1 MASK: RW, per-bit interrupt enable
  - 2 CAPTURE: R/W1C, per-bit latched press events
  - 3 RELOAD: RW, bits [15:0], debounce length N
- Writes to DATA are ignored. Unused upper bits read 0.
- Synchroniser: two flops per bit (sync1, sync2). Both reset to all-ones.
- Debouncer, per bit:
  - stable register, reset all-ones; 16-bit counter cnt, reset 0.
  - If sync2 == stable: cnt <= 0.
  - Else if cnt == N_eff-1: stable <= sync2 and cnt <= 0.
  - Else: cnt <= cnt+1.
  - N_eff = max(RELOAD, 1), so a RELOAD of 0 behaves as 1.
- Edge capture: when stable transitions 1->0 (press), CAPTURE bit is set on the same edge. Releases (0->1) are not captured.
- CAPTURE clear: writing a 1 to a bit at address 2 clears it; writing 0 leaves it unchanged. If a set and a clear hit the same bit in the same cycle, the set wins.
- irq <= |(CAPTURE & MASK), registered from the current register values.
- Read path: readdata <= chipselect ? mux(address) : 0, registered every cycle. Reads have no side effects.
- A RELOAD write takes effect on the next cycle. Counters already in flight compare against the new value; if cnt is already ≥ N_eff-1, the bit commits on the next mismatching cycle.
- Reset values: readdata 0, irq 0, MASK 0, CAPTURE 0, RELOAD DEBOUNCE_DEFAULT, stable all-ones, sync all-ones, cnt 0.
- Reset asserted mid-debounce: all state returns to reset values on that edge, and no capture is generated.

## Timing
- Synchroniser latency: a pin change sampled at edge k appears on sync2 after edge k+1.
- Debounce: stable commits at edge k+1+N_eff, provided sync2 differs from stable on every one of those N_eff cycles. Any single-cycle return to the stable value restarts the count.
- CAPTURE sets at the same edge as stable; irq rises one edge later.
- Read latency: 1 cycle. Address/chipselect at edge t gives readdata valid after edge t.
- Write takes effect at the sampling edge. A read of the same register on the next cycle returns the new value.
- irq falls one edge after the clearing write or the mask write.
- Write and read are never stalled; there is no waitrequest.

## Test plan
- Reset check: hold reset_n=0 for 3 cycles with in_port=0x00 → readdata=0, irq=0. After release, DATA reads 0xFF until N_eff+2 cycles have elapsed, and RELOAD reads DEBOUNCE_DEFAULT.
- Bounce rejection: RELOAD=8, drive bit0 low for 5 cycles then high, repeated 4 times → DATA stays 0xFF, CAPTURE=0, irq=0.
- Clean press: RELOAD=8, MASK=0x01, drive bit0 low and hold → DATA=0xFE exactly 10 cycles after the pin edge. CAPTURE=0x01 on that edge, irq=1 one cycle later. Releasing the pin restores DATA=0xFF with CAPTURE unchanged.
- W1C and masking: with CAPTURE=0x05 and MASK=0x04, write 0x04 to address 2 → CAPTURE=0x01 and irq falls next cycle. Writing 0x00 leaves CAPTURE unchanged.
- Set/clear collision: time a W1C of bit1 onto the exact edge where bit1 commits a press → CAPTURE bit1 reads 1.
- RELOAD=0 and reset mid-count: with RELOAD=0, a one-cycle low pulse commits after 2 cycles. Separately, with RELOAD=8, assert reset_n=0 at cnt=5 → after release, CAPTURE=0 and cnt restarts from 0.
